id_ctrl_hazard: RTL
===================

Name: id_ctrl_hazard

Overview:
Decode-stage controller for the 5-stage RV32I pipeline. It decodes InstrD into control bits, including the ImmSrcD select that drives the immediate sign-extender. It registers those control bits into the ID/EX control register and detects load-use hazards, stalling F/D and inserting a bubble into E. It also takes the branch-taken flush from E and counts stall cycles.

Parameters:
STALL_CNT_W, 16, width of saturating load-use stall counter
NOP_ON_ILLEGAL, 1, 1 = illegal opcode decodes to all-zero controls (bubble); 0 = controls are don't-care, but IllegalE is still flagged

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
InstrD  in  32  instruction in Decode
ValidD  in  1  InstrD holds a real instruction
FlushE  in  1  branch/jump taken in E; kill D and E contents
ImmSrcD  out  2  immediate select to sign-extender, combinational from InstrD
Rs1D  out  5  InstrD[19:15]
Rs2D  out  5  InstrD[24:20]
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
RegWriteE  out  1  registered control
MemWriteE  out  1  registered control
ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
ALUSrcE  out  1  1 = immediate operand
ALUOpE  out  2  00 add, 01 sub (branch), 10 funct-decoded
BranchE  out  1  registered control
JumpE  out  1  registered control
RdE  out  5  registered InstrD[11:7]
ValidE  out  1  E holds a real instruction
IllegalE  out  1  E instruction had an unsupported opcode
StallCnt  out  STALL_CNT_W  load-use stall cycles, saturating

Behaviour:
- Reset (async, rst=1): all E-stage outputs and StallCnt clear to 0 immediately and stay 0 while rst is high. StallF/StallD are 0 during reset.
- Decode (combinational), by opcode InstrD[6:0]:
  - 0000011 lw: RegW=1, ResSrc=01, ALUSrc=1, Imm=00, ALUOp=00.
  - 0100011 sw: MemW=1, ALUSrc=1, Imm=01.
  - 0110011 R: RegW=1, ALUOp=10.
  - 0010011 I-ALU: RegW=1, ALUSrc=1, Imm=00, ALUOp=10.
  - 1100011 beq: Branch=1, Imm=10, ALUOp=01.
  - 1101111 jal: RegW=1, Jump=1, ResSrc=10, Imm=11.
  - Anything else is illegal: all controls 0, ImmSrcD=00.
- ImmSrc encoding: 00 = I-type, 01 = S-type (the two forms the sign-extender supports today), 10 = B-type, 11 = J-type (the extender will gain these).
- Operand usage:
  - rs1 is used by lw, sw, R, I-ALU and beq.
  - rs2 is used by sw, R and beq.
  - jal uses neither.
- Load-use hazard (lu), all of the following true:
  - ValidE=1 and ResultSrcE=01;
  - RdE≠0;
  - ValidD=1;
  - (RdE==Rs1D and rs1 used) or (RdE==Rs2D and rs2 used).
- Outputs: StallF = StallD = lu & ~FlushE (combinational). Flush has priority over stall, because the D instruction is wrong-path.
- E register update (every rising edge when rst=0):
  - FlushE=1 or lu=1: load a bubble. All controls are 0, ValidE=0, IllegalE=0, RdE=0.
  - Otherwise: load the decoded controls. ValidE=ValidD, IllegalE=ValidD & illegal, RdE=InstrD[11:7].
  - ValidD=0: controls are forced to 0.
- Latency: one cycle from D to E. A stall lasts exactly one cycle per load-use, because the bubble clears the hazard the next cycle.
- StallCnt: increments on each cycle where StallF=1. It saturates at all-ones and does not wrap.
- Back-to-back loads: a lw in D dependent on a lw in E stalls 1 cycle. A dependent lw does not stall against a non-load.
- rd=x0: never stalls.
- Reset mid-stall: the stall drops with reset and the E bubble is held. No partial state remains.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode localparams: OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL;
  - ImmSrc encodings: IMM_I, IMM_S, IMM_B, IMM_J;
  - ResultSrc encodings: RES_ALU, RES_MEM, RES_PC4;
  - ALUOp encodings.
- One natural sub-module is main_decoder: purely combinational, InstrD opcode to control bundle plus illegal and rs-used flags. id_ctrl_hazard instantiates it and adds the hazard logic, the E register and the counter.

Test Plan:
- Reset: assert rst asynchronously between edges with ValidD=1 lw in D. All E outputs go to 0 immediately, StallCnt=0.
- Decode/ImmSrc:
  - sw x5,8(x2) (0x00512423): ImmSrcD=01, and next cycle MemWriteE=1, ALUSrcE=1, RegWriteE=0.
  - jal (0x008000EF): ImmSrcD=11, then JumpE=1, ResultSrcE=10, RdE=1.
- Load-use:
  - Stimulus: lw x6,0(x1) followed by add x7,x6,x3.
  - Cycle the add is in D: StallF=StallD=1.
  - Next edge: ValidE=0 with all controls 0, StallCnt=1.
  - Following edge: add reaches E with RegWriteE=1, RdE=7.
- No-stall cases:
  - lw x0 followed by add using x0: no stall.
  - lw x6 followed by jal: no stall.
  - addi x6 followed by add x6: no stall.
- Flush priority: lu condition true and FlushE=1 in the same cycle. StallF=0, E gets a bubble, StallCnt unchanged.
- Illegal and saturation:
  - Opcode 0x7F with ValidD=1: IllegalE=1, all controls 0.
  - With STALL_CNT_W=2, force 5 load-use stalls: StallCnt holds at 3.

Source files
------------

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Constants and types shared by the RV32I decode-stage control logic. It holds
// the opcode values, the immediate-select / result-select / ALU-op encodings,
// and the packed control bundle that travels from Decode into the ID/EX
// control register.
// ---------------------------------------------------------------------------
package riscv_pkg;

    // Major opcodes (InstrD[6:0]) handled by this pipeline
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Immediate-format select for the sign-extender
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Writeback result select
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Control bundle registered from D into E. An all-zero value is a bubble.
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       branch;
        logic       jump;
    } ctrl_t;

endpackage

// File: rtl/main_decoder.sv
// ---------------------------------------------------------------------------
// main_decoder
// Purely combinational opcode decoder for the Decode stage.
//   op        in  7  InstrD[6:0]
//   ctrl      out    control bundle (all zero for unsupported opcodes)
//   imm_src   out 2  immediate format for the sign-extender
//   illegal   out 1  opcode is not one this pipeline supports
//   rs1_used  out 1  instruction reads rs1 (used for hazard detection)
//   rs2_used  out 1  instruction reads rs2 (used for hazard detection)
// ---------------------------------------------------------------------------
module main_decoder
    import riscv_pkg::*;
(
    input  logic [6:0] op,
    output ctrl_t      ctrl,
    output logic [1:0] imm_src,
    output logic       illegal,
    output logic       rs1_used,
    output logic       rs2_used
);

    always_comb begin
        ctrl     = '0;
        imm_src  = IMM_I;
        illegal  = 1'b0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (op)
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_op     = ALUOP_ADD;
                imm_src         = IMM_I;
                rs1_used        = 1'b1;
            end
            OP_STORE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                imm_src         = IMM_S;
                rs1_used        = 1'b1;
                rs2_used        = 1'b1;
            end
            OP_RTYPE: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_op     = ALUOP_FUNCT;
                rs1_used        = 1'b1;
                rs2_used        = 1'b1;
            end
            OP_ITYPE: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_op     = ALUOP_FUNCT;
                imm_src         = IMM_I;
                rs1_used        = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.branch     = 1'b1;
                ctrl.alu_op     = ALUOP_SUB;
                imm_src         = IMM_B;
                rs1_used        = 1'b1;
                rs2_used        = 1'b1;
            end
            OP_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = RES_PC4;
                imm_src         = IMM_J;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_ctrl_hazard.sv
// ---------------------------------------------------------------------------
// id_ctrl_hazard
// Decode-stage controller: decodes InstrD, registers the controls into the
// ID/EX control register, detects load-use hazards (stall F/D, bubble into E),
// honours the branch-taken flush from E and counts load-use stall cycles.
//   clk, rst                 clock, asynchronous active-high reset
//   InstrD, ValidD           instruction in Decode and its valid flag
//   FlushE                   taken branch/jump in E: kill D and E
//   ImmSrcD, Rs1D, Rs2D      combinational decode outputs
//   StallF, StallD           hold PC / IF-ID register on a load-use hazard
//   RegWriteE .. JumpE       registered controls
//   RdE, ValidE, IllegalE    registered destination / valid / illegal flags
//   StallCnt                 saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module id_ctrl_hazard
    import riscv_pkg::*;
#(
    parameter int STALL_CNT_W    = 16,
    parameter bit NOP_ON_ILLEGAL = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            InstrD,
    input  logic                   ValidD,
    input  logic                   FlushE,
    output logic [1:0]             ImmSrcD,
    output logic [4:0]             Rs1D,
    output logic [4:0]             Rs2D,
    output logic                   StallF,
    output logic                   StallD,
    output logic                   RegWriteE,
    output logic                   MemWriteE,
    output logic [1:0]             ResultSrcE,
    output logic                   ALUSrcE,
    output logic [1:0]             ALUOpE,
    output logic                   BranchE,
    output logic                   JumpE,
    output logic [4:0]             RdE,
    output logic                   ValidE,
    output logic                   IllegalE,
    output logic [STALL_CNT_W-1:0] StallCnt
);

    ctrl_t dec_ctrl;
    logic  dec_illegal;
    logic  rs1_used;
    logic  rs2_used;

    main_decoder u_main_decoder (
        .op       (InstrD[6:0]),
        .ctrl     (dec_ctrl),
        .imm_src  (ImmSrcD),
        .illegal  (dec_illegal),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used)
    );

    assign Rs1D = InstrD[19:15];
    assign Rs2D = InstrD[24:20];

    // funct3/funct7 are consumed by the ALU decoder further down the pipe
    logic unused_instr_bits;
    assign unused_instr_bits = &{1'b0, InstrD[31:25], InstrD[14:12]};

    ctrl_t ctrl_e;
    logic  lu;
    logic  bubble;
    logic  rs1_hit;
    logic  rs2_hit;

    // A load in E whose destination is read by the valid instruction in D.
    // x0 is never a real dependency, so rd=0 cannot cause a stall.
    assign rs1_hit = rs1_used && (RdE == Rs1D);
    assign rs2_hit = rs2_used && (RdE == Rs2D);
    assign lu      = ValidE && (ResultSrcE == RES_MEM) && (RdE != 5'd0) &&
                     ValidD && (rs1_hit || rs2_hit);

    // The D instruction is wrong-path when E flushes, so flush wins over stall
    assign StallF = lu && !FlushE;
    assign StallD = StallF;
    assign bubble = FlushE || lu;

    ctrl_t ctrl_next;
    logic  valid_next;
    logic  illegal_next;
    logic  [4:0] rd_next;

    always_comb begin
        ctrl_next    = '0;
        valid_next   = 1'b0;
        illegal_next = 1'b0;
        rd_next      = 5'd0;
        if (!bubble) begin
            valid_next   = ValidD;
            illegal_next = ValidD && dec_illegal;
            rd_next      = InstrD[11:7];
            // Illegal opcodes may optionally pass through as a bubble
            if (ValidD && !(NOP_ON_ILLEGAL && dec_illegal)) begin
                ctrl_next = dec_ctrl;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_e   <= '0;
            ValidE   <= 1'b0;
            IllegalE <= 1'b0;
            RdE      <= 5'd0;
        end else begin
            ctrl_e   <= ctrl_next;
            ValidE   <= valid_next;
            IllegalE <= illegal_next;
            RdE      <= rd_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StallCnt <= '0;
        end else if (StallF && (StallCnt != {STALL_CNT_W{1'b1}})) begin
            StallCnt <= StallCnt + STALL_CNT_W'(1);
        end
    end

    assign RegWriteE  = ctrl_e.reg_write;
    assign MemWriteE  = ctrl_e.mem_write;
    assign ResultSrcE = ctrl_e.result_src;
    assign ALUSrcE    = ctrl_e.alu_src;
    assign ALUOpE     = ctrl_e.alu_op;
    assign BranchE    = ctrl_e.branch;
    assign JumpE      = ctrl_e.jump;

endmodule
